// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction counters,
// round-robin replacement per set, and saturating resolved/mispredict statistics.
module btb_assoc #(
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int CTR_W  = 2,
    parameter int IDX_LO = 1,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_all,
    input  logic [31:0]       pc_1,
    input  logic [31:0]       pc_3,
    input  logic              is_branch_3,
    input  logic              taken_3,
    input  logic              prev_taken_3,
    input  logic [31:0]       pred_target_3,
    input  logic [31:0]       target_3,
    output logic [31:0]       branch_pc,
    output logic              taken,
    output logic              flush,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = 32 - TAG_LO;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t [SETS-1:0][WAYS-1:0] tbl_q, tbl_d;
    logic   [SETS-1:0][PTR_W-1:0] ptr_q, ptr_d;
    logic   [STAT_W-1:0]          br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] idx_1, idx_3;
    logic [TAG_W-1:0] tag_1, tag_3;
    logic             hit_1, hit_3, inv_found, mispredict;
    logic [PTR_W-1:0] way_1, way_3, inv_way, victim;
    entry_t           entry_1;

    assign idx_1 = pc_1[TAG_LO-1:IDX_LO];
    assign tag_1 = pc_1[31:TAG_LO];
    assign idx_3 = pc_3[TAG_LO-1:IDX_LO];
    assign tag_3 = pc_3[31:TAG_LO];

    always_comb begin
        hit_1 = 1'b0;
        way_1 = '0;
        hit_3 = 1'b0;
        way_3 = '0;
        inv_found = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (tbl_q[idx_1][w].valid && tbl_q[idx_1][w].tag == tag_1) begin
                hit_1 = 1'b1;
                way_1 = PTR_W'(w);
            end
            if (tbl_q[idx_3][w].valid && tbl_q[idx_3][w].tag == tag_3) begin
                hit_3 = 1'b1;
                way_3 = PTR_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!tbl_q[idx_3][w].valid) begin
                inv_found = 1'b1;
                inv_way = PTR_W'(w);
            end
        end
        victim = inv_found ? inv_way : ptr_q[idx_3];
    end

    assign entry_1    = tbl_q[idx_1][way_1];
    assign taken      = hit_1 & entry_1.ctr[CTR_W-1];
    assign mispredict = is_branch_3 & ((prev_taken_3 != taken_3) |
                        (prev_taken_3 & taken_3 & (pred_target_3 != target_3)));
    assign flush      = mispredict;

    always_comb begin
        if (mispredict)
            branch_pc = taken_3 ? target_3 : pc_3 + 32'd4;
        else
            branch_pc = taken ? entry_1.target : pc_1 + 32'd4;
    end

    always_comb begin
        tbl_d    = tbl_q;
        ptr_d    = ptr_q;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (!stall && is_branch_3) begin
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
            if (mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
            if (!flush_all) begin
                if (hit_3) begin
                    if (taken_3 && tbl_q[idx_3][way_3].target != target_3) begin
                        tbl_d[idx_3][way_3].target = target_3;
                        tbl_d[idx_3][way_3].ctr    = CTR_WEAK;
                    end else if (taken_3 && tbl_q[idx_3][way_3].ctr != CTR_MAX) begin
                        tbl_d[idx_3][way_3].ctr = tbl_q[idx_3][way_3].ctr + 1'b1;
                    end else if (!taken_3 && tbl_q[idx_3][way_3].ctr != '0) begin
                        tbl_d[idx_3][way_3].ctr = tbl_q[idx_3][way_3].ctr - 1'b1;
                    end
                end else if (taken_3) begin
                    tbl_d[idx_3][victim].valid  = 1'b1;
                    tbl_d[idx_3][victim].tag    = tag_3;
                    tbl_d[idx_3][victim].target = target_3;
                    tbl_d[idx_3][victim].ctr    = CTR_WEAK;
                    if (victim == ptr_q[idx_3])
                        ptr_d[idx_3] = (ptr_q[idx_3] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[idx_3] + 1'b1;
                end
            end
        end
        if (!stall && flush_all) begin
            ptr_d = '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    tbl_d[s][w].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_q    <= '0;
            ptr_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            tbl_q    <= tbl_d;
            ptr_q    <= ptr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: reset, combinational vector table, directed corner sequences,
// then randomized traffic against a set/way reference model.
module tb_btb_assoc;
    localparam int NS = 16;
    localparam int NW = 2;

    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush_all = 1'b0;
    logic [31:0] pc_1 = '0, pc_3 = '0, pred_target_3 = '0, target_3 = '0;
    logic is_branch_3 = 1'b0, taken_3 = 1'b0, prev_taken_3 = 1'b0;
    logic [31:0] branch_pc, branch_pc4;
    logic taken, flush, taken4, flush4;
    logic [31:0] stat_branches, stat_mispredicts;
    logic [3:0]  stat_br4, stat_mp4;

    always #5 clk = ~clk;

    btb_assoc dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_all(flush_all),
        .pc_1(pc_1), .pc_3(pc_3), .is_branch_3(is_branch_3), .taken_3(taken_3),
        .prev_taken_3(prev_taken_3), .pred_target_3(pred_target_3), .target_3(target_3),
        .branch_pc(branch_pc), .taken(taken), .flush(flush),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));

    btb_assoc #(.STAT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush_all(flush_all),
        .pc_1(pc_1), .pc_3(pc_3), .is_branch_3(is_branch_3), .taken_3(taken_3),
        .prev_taken_3(prev_taken_3), .pred_target_3(pred_target_3), .target_3(target_3),
        .branch_pc(branch_pc4), .taken(taken4), .flush(flush4),
        .stat_branches(stat_br4), .stat_mispredicts(stat_mp4));

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: explicit sets of ways, counters as plain integers.
    bit              mv[NS][NW];
    int unsigned     mtag[NS][NW], mtgt[NS][NW];
    int              mctr[NS][NW];
    int              mptr[NS];
    longint          m_br, m_mp;

    function automatic int m_idx(input logic [31:0] pc); return int'((pc >> 1) % NS); endfunction
    function automatic int unsigned m_tag(input logic [31:0] pc); return pc >> 5; endfunction

    task automatic m_lookup(input logic [31:0] pc, output bit hit, output int way);
        hit = 0; way = 0;
        for (int w = 0; w < NW; w++)
            if (mv[m_idx(pc)][w] && mtag[m_idx(pc)][w] == m_tag(pc)) begin hit = 1; way = w; end
    endtask

    function automatic bit m_mispred();
        return is_branch_3 && (prev_taken_3 != taken_3 ||
               (prev_taken_3 && taken_3 && pred_target_3 != target_3));
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < NW; w++) begin mv[s][w] = 0; mctr[s][w] = 0; mtag[s][w] = 0; mtgt[s][w] = 0; end
        end
        m_br = 0; m_mp = 0;
    endtask

    task automatic m_clock();
        bit hit; int way, s, vic;
        if (rst || stall) return;
        if (is_branch_3) begin
            m_br++;
            if (m_mispred()) m_mp++;
            if (!flush_all) begin
                m_lookup(pc_3, hit, way);
                s = m_idx(pc_3);
                if (hit) begin
                    if (taken_3 && mtgt[s][way] != target_3) begin
                        mtgt[s][way] = target_3; mctr[s][way] = 2;
                    end else if (taken_3) mctr[s][way] = (mctr[s][way] < 3) ? mctr[s][way] + 1 : 3;
                    else mctr[s][way] = (mctr[s][way] > 0) ? mctr[s][way] - 1 : 0;
                end else if (taken_3) begin
                    vic = -1;
                    for (int w = NW - 1; w >= 0; w--) if (!mv[s][w]) vic = w;
                    if (vic < 0) vic = mptr[s];
                    if (vic == mptr[s]) mptr[s] = (mptr[s] + 1) % NW;
                    mv[s][vic] = 1; mtag[s][vic] = m_tag(pc_3); mtgt[s][vic] = target_3; mctr[s][vic] = 2;
                end
            end
        end
        if (flush_all)
            for (int i = 0; i < NS; i++) begin
                mptr[i] = 0;
                for (int w = 0; w < NW; w++) mv[i][w] = 0;
            end
    endtask

    task automatic check_all(input string nm);
        bit hit; int way; logic e_tk; logic [31:0] e_bpc;
        m_lookup(pc_1, hit, way);
        e_tk = hit && mctr[m_idx(pc_1)][way] >= 2;
        if (m_mispred()) e_bpc = taken_3 ? target_3 : pc_3 + 32'd4;
        else e_bpc = e_tk ? mtgt[m_idx(pc_1)][way] : pc_1 + 32'd4;
        chk({nm, ".taken"}, {31'b0, taken}, {31'b0, e_tk});
        chk({nm, ".branch_pc"}, branch_pc, e_bpc);
        chk({nm, ".flush"}, {31'b0, flush}, {31'b0, m_mispred()});
        chk({nm, ".stat_br"}, stat_branches, 32'(m_br));
        chk({nm, ".stat_mp"}, stat_mispredicts, 32'(m_mp));
        chk({nm, ".stat_br4"}, {28'b0, stat_br4}, (m_br > 15) ? 32'd15 : 32'(m_br));
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic drive(input logic [31:0] p1, p3, input logic br, tk, ptk, input logic [31:0] ptgt, tgt);
        pc_1 = p1; pc_3 = p3; is_branch_3 = br; taken_3 = tk; prev_taken_3 = ptk;
        pred_target_3 = ptgt; target_3 = tgt;
    endtask

    task automatic resolve(input logic [31:0] p3, input logic tk, ptk, input logic [31:0] ptgt, tgt);
        drive(pc_1, p3, 1'b1, tk, ptk, ptgt, tgt);
        #1 check_all("resolve");
        tick();
        is_branch_3 = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [31:0] p1, input logic e_tk, input logic [31:0] e_bpc);
        drive(p1, pc_3, 1'b0, taken_3, prev_taken_3, pred_target_3, target_3);
        #1;
        chk({nm, ".taken"}, {31'b0, taken}, {31'b0, e_tk});
        chk({nm, ".bpc"}, branch_pc, e_bpc);
        check_all(nm);
    endtask

    typedef struct {
        logic [31:0] pc1, pc3;
        logic        br, tk, ptk;
        logic [31:0] ptgt, tgt;
        logic        e_flush;
        logic [31:0] e_bpc;
    } vec_t;

    initial begin
        vec_t vt[7];
        logic [31:0] sb, sm;
        bit hit; int way;
        vt[0] = '{32'h100, 32'h40, 0, 1, 0, 32'h0, 32'h500, 0, 32'h104};
        vt[1] = '{32'h100, 32'h40, 1, 1, 0, 32'h0, 32'h500, 1, 32'h500};
        vt[2] = '{32'h100, 32'h40, 1, 0, 1, 32'h500, 32'h500, 1, 32'h44};
        vt[3] = '{32'hFFFF_FFFC, 32'h40, 1, 1, 1, 32'h500, 32'h500, 0, 32'h0};
        vt[4] = '{32'h100, 32'h40, 1, 1, 1, 32'h600, 32'h500, 1, 32'h500};
        vt[5] = '{32'h100, 32'h40, 1, 0, 0, 32'h600, 32'h500, 0, 32'h104};
        vt[6] = '{32'h100, 32'hFFFF_FFFC, 1, 0, 1, 32'h0, 32'h0, 1, 32'h0};
        m_reset();

        // Reset held: outputs idle, flush still combinational, update across edge discarded.
        drive(32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        #3;
        chk("rst.flush", {31'b0, flush}, 32'd1);
        chk("rst.taken", {31'b0, taken}, 32'd0);
        chk("rst.bpc", branch_pc, 32'h104);
        chk("rst.stat_br", stat_branches, 32'd0);
        chk("rst.stat_mp", stat_mispredicts, 32'd0);
        drive(32'h100, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0, 32'h200);
        @(posedge clk); #1;
        rst = 1'b0;
        is_branch_3 = 1'b0;
        lookup("rst_discard", 32'h100, 1'b0, 32'h104);

        // Combinational vector table on an empty table, stalled.
        stall = 1'b1;
        foreach (vt[i]) begin
            drive(vt[i].pc1, vt[i].pc3, vt[i].br, vt[i].tk, vt[i].ptk, vt[i].ptgt, vt[i].tgt);
            #1;
            chk($sformatf("vec%0d.flush", i), {31'b0, flush}, {31'b0, vt[i].e_flush});
            chk($sformatf("vec%0d.bpc", i), branch_pc, vt[i].e_bpc);
            chk($sformatf("vec%0d.taken", i), {31'b0, taken}, 32'd0);
        end
        chk("vec.stat_br", stat_branches, 32'd0);
        @(posedge clk); #1;
        stall = 1'b0;
        drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Cold miss then allocate.
        lookup("cold", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 32'h200);
        lookup("alloc", 32'h100, 1'b1, 32'h200);

        // Direction mispredict.
        drive(32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 32'h200);
        #1;
        chk("dirmp.flush", {31'b0, flush}, 32'd1);
        chk("dirmp.bpc", branch_pc, 32'h104);
        tick();
        is_branch_3 = 1'b0;
        lookup("dirmp.ctr1", 32'h100, 1'b0, 32'h104);
        chk("dirmp.stat_mp", stat_mispredicts, 32'd2);
        chk("dirmp.stat_br", stat_branches, 32'd2);

        // Saturation up and down.
        repeat (4) resolve(32'h100, 1'b1, 1'b1, 32'h200, 32'h200);
        lookup("sat.hi", 32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b0, 1'b1, 32'h200, 32'h200);
        lookup("sat.3to2", 32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b0, 1'b1, 32'h200, 32'h200);
        lookup("sat.2to1", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1'b0, 1'b0, 32'h200, 32'h200);
        resolve(32'h100, 1'b0, 1'b0, 32'h200, 32'h200);
        resolve(32'h100, 1'b1, 1'b0, 32'h200, 32'h200);
        lookup("sat.floor", 32'h100, 1'b0, 32'h104);

        // Replacement in set 1.
        resolve(32'h1002, 1'b1, 1'b0, 32'h0, 32'hA00);
        resolve(32'h2002, 1'b1, 1'b0, 32'h0, 32'hB00);
        resolve(32'h3002, 1'b1, 1'b0, 32'h0, 32'hC00);
        lookup("repl3.way0", 32'h1002, 1'b0, 32'h1006);
        lookup("repl3.keep", 32'h2002, 1'b1, 32'hB00);
        lookup("repl3.new", 32'h3002, 1'b1, 32'hC00);
        chk("repl3.ptr", mptr[1], 1);
        resolve(32'h4002, 1'b1, 1'b0, 32'h0, 32'hD00);
        lookup("repl4.way1", 32'h2002, 1'b0, 32'h2006);
        lookup("repl4.keep", 32'h3002, 1'b1, 32'hC00);
        lookup("repl4.new", 32'h4002, 1'b1, 32'hD00);

        // Stall with a mispredicting branch, then flush_all.
        sb = stat_branches; sm = stat_mispredicts;
        stall = 1'b1;
        drive(32'h3002, 32'h3002, 1'b1, 1'b0, 1'b1, 32'hC00, 32'hC00);
        #1;
        chk("stall.flush", {31'b0, flush}, 32'd1);
        chk("stall.bpc", branch_pc, 32'h3006);
        tick();
        stall = 1'b0;
        is_branch_3 = 1'b0;
        lookup("stall.hold", 32'h3002, 1'b1, 32'hC00);
        chk("stall.stat_br", stat_branches, sb);
        chk("stall.stat_mp", stat_mispredicts, sm);
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        lookup("fa.miss3", 32'h3002, 1'b0, 32'h3006);
        lookup("fa.miss4", 32'h4002, 1'b0, 32'h4006);
        lookup("fa.miss0", 32'h100, 1'b0, 32'h104);
        chk("fa.stat_br", stat_branches, sb);
        chk("fa.stat_mp", stat_mispredicts, sm);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            pc_1 = 32'h1000 + (32'($urandom_range(3)) << 5) + (32'($urandom_range(3)) << 1);
            pc_3 = 32'h1000 + (32'($urandom_range(3)) << 5) + (32'($urandom_range(3)) << 1);
            is_branch_3 = ($urandom_range(99) < 70);
            taken_3 = $urandom_range(1);
            target_3 = 32'h800 + (32'($urandom_range(2)) << 8);
            if ($urandom_range(1)) begin
                m_lookup(pc_3, hit, way);
                prev_taken_3 = hit && mctr[m_idx(pc_3)][way] >= 2;
                pred_target_3 = hit ? mtgt[m_idx(pc_3)][way] : pc_3 + 32'd4;
            end else begin
                prev_taken_3 = $urandom_range(1);
                pred_target_3 = 32'h800 + (32'($urandom_range(2)) << 8);
            end
            stall = ($urandom_range(99) < 15);
            flush_all = ($urandom_range(99) < 3);
            #1 check_all($sformatf("rand%0d", c));
            tick();
        end
        stall = 1'b0; flush_all = 1'b0; is_branch_3 = 1'b0;
        #1;
        chk("stat_wrap4", {28'b0, stat_br4}, 32'd15);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
